// File: rtl/simplez_io.sv
// Memory-mapped LED register and 8N1 UART transmitter at word addresses 0x1FC..0x1FF.
// Reads return on dout one cycle after the strobe; TXDATA writes while busy are dropped and flagged as overrun.
module simplez_io #(
  parameter int BAUD_DIV = 104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  addr,
  input  logic [11:0] din,
  input  logic        we,
  input  logic        rd,
  output logic        hit,
  output logic [11:0] dout,
  output logic [3:0]  leds,
  output logic        tx
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bitn, bitn_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          overrun, overrun_nx;
  logic          ready;
  logic          wr_en, rd_en;
  logic          wr_leds, wr_txdata, rd_txstat;
  logic          baud_last;
  logic [11:0]   rdata;
  logic          unused_din;

  assign unused_din = ^din[11:8];

  // Decode: the top four words of the 512-word space.
  assign hit   = (addr[8:2] == 7'h7f);
  assign wr_en = we & hit & ~rst;
  assign rd_en = rd & hit & ~rst;

  assign wr_leds   = wr_en & (addr[1:0] == 2'd0);
  assign wr_txdata = wr_en & (addr[1:0] == 2'd1);
  assign rd_txstat = rd_en & (addr[1:0] == 2'd2);

  assign ready     = (state == IDLE);
  assign baud_last = (cnt == CNT_LAST);

  // Read mux sees pre-write state, so a same-cycle write+read returns the old value.
  always_comb begin
    rdata = 12'h000;
    case (addr[1:0])
      2'd0:    rdata = {8'h00, leds};
      2'd2:    rdata = {10'h000, overrun, ready};
      default: rdata = 12'h000;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bitn_nx  = bitn;
    shreg_nx = shreg;
    case (state)
      IDLE: begin
        if (wr_txdata) begin
          state_nx = START;
          cnt_nx   = '0;
          shreg_nx = din[7:0];
        end
      end
      START: begin
        if (baud_last) begin
          state_nx = DATA;
          cnt_nx   = '0;
          bitn_nx  = 3'd0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          cnt_nx   = '0;
          shreg_nx = {1'b0, shreg[7:1]};
          if (bitn == 3'd7) begin
            state_nx = STOP;
          end else begin
            bitn_nx = bitn + 3'd1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // A busy write sets overrun even when a status read clears it in the same cycle.
  always_comb begin
    overrun_nx = overrun;
    if (rd_txstat) begin
      overrun_nx = 1'b0;
    end
    if (wr_txdata && !ready) begin
      overrun_nx = 1'b1;
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bitn    <= 3'd0;
      shreg   <= 8'h00;
      overrun <= 1'b0;
      leds    <= 4'h0;
      dout    <= 12'h000;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bitn    <= bitn_nx;
      shreg   <= shreg_nx;
      overrun <= overrun_nx;
      if (wr_leds) begin
        leds <= din[3:0];
      end
      if (rd_en) begin
        dout <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_simplez_io.sv
// Scoreboard bench for simplez_io with BAUD_DIV = 4: read data and UART frames are queued at issue and checked by monitors.
module tb_simplez_io;

  localparam int BD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  addr = 9'h000;
  logic [11:0] din = 12'h000;
  logic        we = 1'b0;
  logic        rd = 1'b0;
  logic        hit;
  logic [11:0] dout;
  logic [3:0]  leds;
  logic        tx;

  int errors = 0;
  int checks = 0;

  logic [11:0] rdq[$];
  logic [7:0]  txq[$];

  simplez_io #(.BAUD_DIV(BD)) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .din  (din),
    .we   (we),
    .rd   (rd),
    .hit  (hit),
    .dout (dout),
    .leds (leds),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] a, input logic [11:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    step(1);
    we   = 1'b0;
  endtask

  task automatic rd_exp(input logic [8:0] a, input logic [11:0] exp);
    addr = a;
    rd   = 1'b1;
    rdq.push_back(exp);
    step(1);
    rd   = 1'b0;
  endtask

  // Read-data monitor: a qualifying read sampled on an edge presents dout by the next falling edge.
  logic rd_fire = 1'b0;
  always @(posedge clk) rd_fire <= rd && !rst && (addr >= 9'h1fc);

  always @(negedge clk) begin
    if (rd_fire) begin
      if (rdq.size() == 0) begin
        chk("dout_unexpected", dout, 12'hxxx);
      end else begin
        chk("dout", dout, rdq.pop_front());
      end
    end
  end

  // Frame monitor: a falling tx starts a frame; each bit period must hold its value for BD cycles.
  logic       tx_prev = 1'b1;
  logic       in_frame = 1'b0;
  logic       bit_bad = 1'b0;
  logic [7:0] fr_byte = 8'h00;
  int         fr_cyc = 0;

  always @(negedge clk) begin
    logic expb;
    int   bi;
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && tx_prev && !tx) begin
        if (txq.size() == 0) begin
          chk("tx_unexpected_start", {11'h0, tx}, 12'h001);
        end else begin
          fr_byte  = txq.pop_front();
          in_frame = 1'b1;
          fr_cyc   = 0;
          bit_bad  = 1'b0;
        end
      end
      if (in_frame) begin
        bi = fr_cyc / BD;
        if (bi == 0)      expb = 1'b0;
        else if (bi == 9) expb = 1'b1;
        else              expb = fr_byte[bi-1];
        if (tx !== expb) bit_bad = 1'b1;
        if ((fr_cyc % BD) == BD - 1) begin
          chk($sformatf("tx_bit%0d_of_%02h", bi, fr_byte), {11'h0, bit_bad}, 12'h000);
          bit_bad = 1'b0;
        end
        fr_cyc = fr_cyc + 1;
        if (fr_cyc == 10 * BD) in_frame = 1'b0;
      end
    end
    tx_prev = tx;
  end

  initial begin
    step(3);
    rst = 1'b0;
    chk("reset_leds", {8'h0, leds}, 12'h000);
    chk("reset_tx", {11'h0, tx}, 12'h001);
    chk("reset_dout", dout, 12'h000);

    addr = 9'h1fc; #1 chk("hit_1fc", {11'h0, hit}, 12'h001);
    addr = 9'h1ff; #1 chk("hit_1ff", {11'h0, hit}, 12'h001);
    addr = 9'h1fb; #1 chk("hit_1fb", {11'h0, hit}, 12'h000);
    addr = 9'h100; #1 chk("hit_100", {11'h0, hit}, 12'h000);

    // LED write and readback; upper din bits discarded.
    wr(9'h1fc, 12'hfa5);
    chk("leds_after_write", {8'h0, leds}, 12'h005);
    rd_exp(9'h1fc, 12'h005);
    rd_exp(9'h1fe, 12'h001);
    rd_exp(9'h1ff, 12'h000);

    // Same-cycle write and read returns the old value.
    addr = 9'h1fc; din = 12'h00a; we = 1'b1; rd = 1'b1;
    rdq.push_back(12'h005);
    step(1);
    we = 1'b0; rd = 1'b0;
    chk("leds_wr_rd", {8'h0, leds}, 12'h00a);
    rd_exp(9'h1fc, 12'h00a);

    // Off-map access is ignored and dout holds.
    addr = 9'h100; din = 12'hfff; we = 1'b1; rd = 1'b1;
    step(1);
    we = 1'b0; rd = 1'b0;
    chk("leds_offmap", {8'h0, leds}, 12'h00a);
    chk("dout_hold", dout, 12'h00a);
    rd_exp(9'h1ff, 12'h000);

    // Frame 0xA5: busy through the last STOP cycle, ready one cycle later.
    txq.push_back(8'ha5);
    wr(9'h1fd, 12'h0a5);
    chk("tx_start_low", {11'h0, tx}, 12'h000);
    rd_exp(9'h1fe, 12'h000);
    step(38);
    rd_exp(9'h1fe, 12'h000);
    rd_exp(9'h1fe, 12'h001);

    // Overrun mid-frame does not disturb the frame; status read clears it.
    txq.push_back(8'ha5);
    wr(9'h1fd, 12'h0a5);
    step(9);
    wr(9'h1fd, 12'h03c);
    rd_exp(9'h1fe, 12'h002);
    rd_exp(9'h1fe, 12'h000);
    step(28);
    rd_exp(9'h1fe, 12'h001);

    // Write on the final STOP cycle counts as overrun.
    txq.push_back(8'h11);
    wr(9'h1fd, 12'h011);
    step(39);
    wr(9'h1fd, 12'h0ff);
    rd_exp(9'h1fe, 12'h003);
    rd_exp(9'h1fe, 12'h001);

    // Reset mid-frame aborts it; a write during reset is ignored.
    txq.push_back(8'ha5);
    wr(9'h1fd, 12'h0a5);
    step(14);
    rst = 1'b1; addr = 9'h1fc; din = 12'h00f; we = 1'b1;
    step(1);
    rst = 1'b0; we = 1'b0;
    chk("midframe_rst_tx", {11'h0, tx}, 12'h001);
    chk("midframe_rst_leds", {8'h0, leds}, 12'h000);
    chk("midframe_rst_dout", dout, 12'h000);
    rd_exp(9'h1fe, 12'h001);
    txq.push_back(8'h55);
    wr(9'h1fd, 12'h055);
    step(45);
    chk("tx_idle_end", {11'h0, tx}, 12'h001);
    rd_exp(9'h1fe, 12'h001);
    step(2);

    chk("rdq_drained", 12'(rdq.size()), 12'h000);
    chk("txq_drained", 12'(txq.size()), 12'h000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simplez_io.md
SIMPLEZ_IO -- requirements
Module: simplez_io

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 104, meaning clock cycles per UART bit (12 MHz / 115200).
REQ-002 The block SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous active-high reset, sampled on rising edge of clk.
REQ-004 The block SHALL have port addr  input  9  CPU bus word address.
REQ-005 The block SHALL have port din  input  12  CPU write data.
REQ-006 The block SHALL have port we  input  1  CPU write strobe, one cycle per access.
REQ-007 The block SHALL have port rd  input  1  CPU read strobe, one cycle per access.
REQ-008 The block SHALL have port hit  output  1  combinational decode, high when addr is in 0x1FC..0x1FF.
REQ-009 The block SHALL have port dout  output  12  registered read data.
REQ-010 The block SHALL have port leds  output  4  LED register contents.
REQ-011 The block SHALL have port tx  output  1  UART serial output, 8N1, idle high.

Function
REQ-012 Address map SHALL be: 0x1FC LEDS (R/W, bits 3:0); 0x1FD TXDATA (W, bits 7:0); 0x1FE TXSTAT (R: bit0 ready, bit1 overrun); 0x1FF reserved (reads 0, writes ignored).
REQ-013 The block SHALL ignore we/rd when hit is low; unused read bits SHALL return 0.
REQ-014 Read latency SHALL be 1 cycle: dout updates on the edge sampling rd and hit, and holds until the next qualifying read.
REQ-015 Write to LEDS SHALL update leds on the sampling edge; din bits 11:4 are discarded.
REQ-016 Transmitter FSM states SHALL be IDLE, START, DATA, STOP; ready = (state == IDLE).
REQ-017 Write to TXDATA in IDLE SHALL latch din[7:0] and enter START on the same edge; tx goes low the following cycle.
REQ-018 Each state/bit SHALL last exactly BAUD_DIV cycles; DATA shifts 8 bits LSB first; STOP drives tx high; full frame = 10*BAUD_DIV cycles, then IDLE.
REQ-019 Write to TXDATA when not IDLE SHALL NOT alter the frame in progress and SHALL set overrun.
REQ-020 A read of TXSTAT SHALL return current status and clear overrun on the same edge; if a new overrun event coincides, overrun SHALL remain set.
REQ-021 A write to TXDATA on the last STOP cycle SHALL be treated as busy (overrun); ready rises the cycle after STOP ends.
REQ-022 Simultaneous we and rd to the same register SHALL perform the write and return the pre-write value on dout.
REQ-023 The baud counter SHALL be internal, width ceil(log2(BAUD_DIV)), restart at 0 on every state entry.

Reset
REQ-024 On rst: leds = 0, dout = 0, tx = 1, state = IDLE, overrun = 0, shift register and baud counter = 0.
REQ-025 rst asserted mid-frame SHALL abort the frame; tx = 1 on the cycle after the reset edge; no partial resume after release.
REQ-026 we/rd SHALL be ignored while rst is high.

Verification (BAUD_DIV = 4)
REQ-027 Reset then write 0xFA5 to 0x1FC -> leds = 0x5 next cycle; read 0x1FC -> dout = 0x005 one cycle later.
REQ-028 Write 0x0A5 to 0x1FD in IDLE -> tx: low 4 cycles, bits 1,0,1,0,0,1,0,1 each 4 cycles, high 4 cycles; TXSTAT bit0 = 0 during frame, 1 after 40 cycles.
REQ-029 Second write 0x03C to 0x1FD 10 cycles into frame -> frame still carries 0xA5; read 0x1FE -> dout = 0x002; next read 0x1FE -> 0x000 (after frame end 0x001).
REQ-030 Assert rst 15 cycles into a frame for 1 cycle -> tx = 1, leds = 0, TXSTAT reads 0x001; new write 0x055 sends a complete 0x55 frame.
REQ-031 Access to addr 0x100 with we = 1, din = 0xFFF -> hit = 0, leds unchanged; read 0x1FF -> dout = 0x000.
